mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single main-memory port between the instruction-cache and data-cache controllers. Each cache controller issues one-cycle read or write pulses with a line address and data. The arbiter latches each request, grants the memory port round-robin, and returns a one-cycle response pulse plus read data to the winning requester. It sits between the two cache controllers and the memory-side adapter, and adds a response timeout for debugging.

## Interface
- ADDR_W, 32, line address width
- LINE_W, 128, cache line width
- TIMEOUT, 255, max WAIT cycles before forced completion; 0 disables the timeout
- clk  in  1  clock; all registers update on the rising edge
- rst  in  1  asynchronous, active-high reset
- a_read / a_write  in  1  port A (I-cache) request pulses
- a_addr  in  ADDR_W  port A line address, valid with the pulse
- a_wdata  in  LINE_W  port A write data, valid with the pulse
- a_rdata  out  LINE_W  port A read data, valid while a_resp=1
- a_resp  out  1  port A completion pulse
- b_read, b_write, b_addr, b_wdata, b_rdata, b_resp: identical to port A, for port B (D-cache)
- mem_read / mem_write  out  1  one-cycle memory command pulses
- mem_addr  out  ADDR_W, mem_wdata  out  LINE_W  held stable from the command pulse until completion
- mem_rdata  in  LINE_W, mem_resp  in  1  memory completion; mem_rdata is valid when mem_resp=1
- error  out  1  one-cycle debug pulse (timeout or overrun)

## Operation
- Each port has a pending register: pend_v, pend_wr, pend_addr, pend_wdata.
  - A read or write pulse on a port whose pend_v=0 captures the request and sets pend_v.
  - If read and write are both high in the same cycle, the request is a write.
  - A pulse while pend_v=1 is dropped and pulses error (overrun).
  - A pulse on the same edge that port completes is accepted: set wins over clear.
- State machine (registered outputs):
  - IDLE: if no pend_v is set, stay in IDLE.
    - Otherwise select a port. If only one is pending, select it. If both are pending, select the port not in last_grant.
    - Record the grant in cur. Drive mem_read or mem_write for 1 cycle, plus mem_addr and mem_wdata from the pending register.
    - Clear the timer and go to WAIT.
    - mem_resp is ignored in IDLE.
  - WAIT: hold mem_addr and mem_wdata. Increment the timer each cycle.
    - On mem_resp=1: load x_rdata=mem_rdata for the cur port, pulse x_resp, clear that pend_v, set last_grant=cur, go to IDLE.
    - For writes, x_rdata is also loaded with mem_rdata; requesters ignore it.
    - If TIMEOUT≠0, mem_resp=0 and timer==TIMEOUT-1: complete the same way but with x_rdata=0, and pulse error.
- Timer width: $clog2(TIMEOUT+1) bits, saturating; it never wraps.
- Reset values: all outputs 0; state IDLE; pend_v=0 on both ports; last_grant=B (so A wins the first tie); timer=0.
- Reset mid-transaction: the in-flight memory operation is abandoned with no x_resp. A later stray mem_resp arrives in IDLE and is ignored.

## Timing
- Request pulse sampled at edge E0 → pend_v=1 after E0.
- Grant edge E1 (the next edge if idle) → mem_read or mem_write high for exactly one cycle after E1.
- mem_resp sampled at edge Ek (k≥2) → x_resp=1 and x_rdata valid for one cycle after Ek. The arbiter is in IDLE after Ek.
- Next grant at the earliest at Ek+1, so there is one idle cycle between memory commands.
- Minimum request-to-response latency is 3 edges (E0, E1, E2 with mem_resp at E2).
- Only one memory transaction is outstanding at a time. a_resp and b_resp are never high in the same cycle.
- x_rdata holds its value after x_resp drops until the next completion on that port.

## Test plan
- Single read on A, addr 0x40, mem_resp 3 cycles after mem_read with rdata 0xDEAD… → mem_read is 1 cycle with mem_addr 0x40; a_resp is 1 cycle with a_rdata 0xDEAD…; b_resp stays 0.
- A read and B write pulsed in the same cycle after reset → A granted first; after a_resp, B is granted on the next edge with mem_write=1 and mem_wdata=b_wdata.
- Fairness: both ports re-request immediately after each completion for 6 transactions → grant order A,B,A,B,A,B.
- Overrun: B pulses twice 1 cycle apart while its first request is pending → one error pulse, exactly one mem command for B, one b_resp.
- Timeout with TIMEOUT=4: A read, mem_resp never asserted → a_resp and error high in the same cycle 4 cycles after the WAIT entry, a_rdata=0; a subsequent mem_resp in IDLE is ignored.
- rst asserted asynchronously during WAIT → outputs 0 immediately; after release, no a_resp or b_resp, and a new request is processed normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single main-memory port between the I-cache (port A) and the
// D-cache (port B) controllers. Each side fires one-cycle read/write pulses,
// which are parked in a per-port pending register until the memory port is
// free. Grants alternate round-robin when both sides are waiting. Only one
// memory transaction is in flight at a time. A response timeout forces
// completion of a stuck transaction and flags it on o_error.
//
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_a_read, i_a_write               port A request pulses (write wins if both)
//   i_a_addr, i_a_wdata               port A line address / write data
//   o_a_rdata, o_a_resp               port A read data and completion pulse
//   i_b_* / o_b_*                     same as port A, for port B
//   o_mem_read, o_mem_write           one-cycle memory command pulses
//   o_mem_addr, o_mem_wdata           held from the command until completion
//   i_mem_rdata, i_mem_resp           memory completion and its read data
//   o_error                           one-cycle pulse on timeout or overrun
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_read,
    input  logic              i_a_write,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [LINE_W-1:0] i_a_wdata,
    output logic [LINE_W-1:0] o_a_rdata,
    output logic              o_a_resp,
    input  logic              i_b_read,
    input  logic              i_b_write,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [LINE_W-1:0] i_b_wdata,
    output logic [LINE_W-1:0] o_b_rdata,
    output logic              o_b_resp,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [LINE_W-1:0] o_mem_wdata,
    input  logic [LINE_W-1:0] i_mem_rdata,
    input  logic              i_mem_resp,
    output logic              o_error
);

    // A zero TIMEOUT disables the timer, but the counter still needs one bit.
    localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TLIM = TW'(TLIM_I);

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arbState_t;

    arbState_t         r_state;
    arbState_t         w_stateNext;
    logic              r_cur;
    logic              w_curNext;
    logic              r_lastGrant;
    logic              w_lastGrantNext;
    logic [TW-1:0]     r_timer;
    logic [TW-1:0]     w_timerNext;

    logic              r_aPendV;
    logic              r_aPendWr;
    logic [ADDR_W-1:0] r_aPendAddr;
    logic [LINE_W-1:0] r_aPendWdata;
    logic              r_bPendV;
    logic              r_bPendWr;
    logic [ADDR_W-1:0] r_bPendAddr;
    logic [LINE_W-1:0] r_bPendWdata;

    logic              r_memRead;
    logic              r_memWrite;
    logic [ADDR_W-1:0] r_memAddr;
    logic [LINE_W-1:0] r_memWdata;
    logic              r_aResp;
    logic              r_bResp;
    logic [LINE_W-1:0] r_aRdata;
    logic [LINE_W-1:0] r_bRdata;
    logic              r_error;

    logic              w_memReadNext;
    logic              w_memWriteNext;
    logic [ADDR_W-1:0] w_memAddrNext;
    logic [LINE_W-1:0] w_memWdataNext;
    logic              w_aRespNext;
    logic              w_bRespNext;
    logic [LINE_W-1:0] w_aRdataNext;
    logic [LINE_W-1:0] w_bRdataNext;
    logic              w_errorNext;

    logic              w_aDone;
    logic              w_bDone;
    logic              w_grantB;
    logic              w_timeoutHit;
    logic [LINE_W-1:0] w_cplData;
    logic              w_aPulse;
    logic              w_bPulse;
    logic              w_aOverrun;
    logic              w_bOverrun;

    assign w_aPulse = i_a_read | i_a_write;
    assign w_bPulse = i_b_read | i_b_write;

    // A pulse landing on the edge its own port completes is still accepted.
    assign w_aOverrun  = w_aPulse & r_aPendV & ~w_aDone;
    assign w_bOverrun  = w_bPulse & r_bPendV & ~w_bDone;
    assign w_errorNext = w_timeoutHit | w_aOverrun | w_bOverrun;

    // Pending request registers; a new capture takes priority over the clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_aPendV     <= 1'b0;
            r_aPendWr    <= 1'b0;
            r_aPendAddr  <= '0;
            r_aPendWdata <= '0;
            r_bPendV     <= 1'b0;
            r_bPendWr    <= 1'b0;
            r_bPendAddr  <= '0;
            r_bPendWdata <= '0;
        end else begin
            if (w_aPulse && (!r_aPendV || w_aDone)) begin
                r_aPendV     <= 1'b1;
                r_aPendWr    <= i_a_write;
                r_aPendAddr  <= i_a_addr;
                r_aPendWdata <= i_a_wdata;
            end else if (w_aDone) begin
                r_aPendV <= 1'b0;
            end
            if (w_bPulse && (!r_bPendV || w_bDone)) begin
                r_bPendV     <= 1'b1;
                r_bPendWr    <= i_b_write;
                r_bPendAddr  <= i_b_addr;
                r_bPendWdata <= i_b_wdata;
            end else if (w_bDone) begin
                r_bPendV <= 1'b0;
            end
        end
    end

    // Next-state and next-output logic. All outputs are registered, so this
    // block computes what they become on the coming edge.
    always_comb begin
        w_stateNext     = r_state;
        w_curNext       = r_cur;
        w_lastGrantNext = r_lastGrant;
        w_timerNext     = r_timer;
        w_memReadNext   = 1'b0;
        w_memWriteNext  = 1'b0;
        w_memAddrNext   = r_memAddr;
        w_memWdataNext  = r_memWdata;
        w_aRespNext     = 1'b0;
        w_bRespNext     = 1'b0;
        w_aRdataNext    = r_aRdata;
        w_bRdataNext    = r_bRdata;
        w_aDone         = 1'b0;
        w_bDone         = 1'b0;
        w_grantB        = 1'b0;
        w_timeoutHit    = 1'b0;
        w_cplData       = '0;

        case (r_state)
            ST_IDLE: begin
                if (r_aPendV || r_bPendV) begin
                    // On a tie, B wins only if A had the previous grant.
                    w_grantB  = r_bPendV && (!r_aPendV || (r_lastGrant == PORT_A));
                    w_curNext = w_grantB ? PORT_B : PORT_A;
                    if (w_grantB) begin
                        w_memWriteNext = r_bPendWr;
                        w_memReadNext  = ~r_bPendWr;
                        w_memAddrNext  = r_bPendAddr;
                        w_memWdataNext = r_bPendWdata;
                    end else begin
                        w_memWriteNext = r_aPendWr;
                        w_memReadNext  = ~r_aPendWr;
                        w_memAddrNext  = r_aPendAddr;
                        w_memWdataNext = r_aPendWdata;
                    end
                    w_timerNext = '0;
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_timeoutHit = (TIMEOUT != 0) && !i_mem_resp && (r_timer == TLIM);
                if (i_mem_resp || w_timeoutHit) begin
                    w_cplData = i_mem_resp ? i_mem_rdata : '0;
                    if (r_cur == PORT_A) begin
                        w_aDone      = 1'b1;
                        w_aRespNext  = 1'b1;
                        w_aRdataNext = w_cplData;
                    end else begin
                        w_bDone      = 1'b1;
                        w_bRespNext  = 1'b1;
                        w_bRdataNext = w_cplData;
                    end
                    w_lastGrantNext = r_cur;
                    w_stateNext     = ST_IDLE;
                end else if (r_timer != '1) begin
                    w_timerNext = r_timer + TW'(1);
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // State and output registers. last_grant resets to B so A wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cur       <= PORT_A;
            r_lastGrant <= PORT_B;
            r_timer     <= '0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_aResp     <= 1'b0;
            r_bResp     <= 1'b0;
            r_aRdata    <= '0;
            r_bRdata    <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cur       <= w_curNext;
            r_lastGrant <= w_lastGrantNext;
            r_timer     <= w_timerNext;
            r_memRead   <= w_memReadNext;
            r_memWrite  <= w_memWriteNext;
            r_memAddr   <= w_memAddrNext;
            r_memWdata  <= w_memWdataNext;
            r_aResp     <= w_aRespNext;
            r_bResp     <= w_bRespNext;
            r_aRdata    <= w_aRdataNext;
            r_bRdata    <= w_bRdataNext;
            r_error     <= w_errorNext;
        end
    end

    assign o_mem_read  = r_memRead;
    assign o_mem_write = r_memWrite;
    assign o_mem_addr  = r_memAddr;
    assign o_mem_wdata = r_memWdata;
    assign o_a_resp    = r_aResp;
    assign o_b_resp    = r_bResp;
    assign o_a_rdata   = r_aRdata;
    assign o_b_rdata   = r_bRdata;
    assign o_error     = r_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter built with TIMEOUT=4. The bench plays
// the memory side (fixed response delay, or none) and keeps a transaction-level
// model of the arbiter that every cycle predicts all outputs.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          aRead, aWrite, bRead, bWrite;
    logic [AW-1:0] aAddr, bAddr;
    logic [LW-1:0] aWdata, bWdata;
    logic [LW-1:0] aRdata, bRdata;
    logic          aResp, bResp;
    logic          memRead, memWrite;
    logic [AW-1:0] memAddr;
    logic [LW-1:0] memWdata;
    logic [LW-1:0] memRdata;
    logic          memResp;
    logic          errorOut;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_read(aRead), .i_a_write(aWrite), .i_a_addr(aAddr), .i_a_wdata(aWdata),
        .o_a_rdata(aRdata), .o_a_resp(aResp),
        .i_b_read(bRead), .i_b_write(bWrite), .i_b_addr(bAddr), .i_b_wdata(bWdata),
        .o_b_rdata(bRdata), .o_b_resp(bResp),
        .o_mem_read(memRead), .o_mem_write(memWrite), .o_mem_addr(memAddr),
        .o_mem_wdata(memWdata), .i_mem_rdata(memRdata), .i_mem_resp(memResp),
        .o_error(errorOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [LW-1:0] memData(input logic [AW-1:0] addr);
        return {32'hDEADBEEF, addr, ~addr, 32'h0BADF00D};
    endfunction

    task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: respDelay>0 answers that many cycles after the command
    int            respDelay = 0;
    logic          strayResp = 1'b0;
    int            pendCnt;
    logic [AW-1:0] pendAddr;

    initial begin
        memResp  = 1'b0;
        memRdata = '0;
        pendCnt  = 0;
        pendAddr = '0;
        forever begin
            @(negedge clk);
            #1;
            memResp = strayResp;
            if (rst) begin
                pendCnt = 0;
            end else begin
                if ((memRead || memWrite) && respDelay > 0) begin
                    pendCnt  = respDelay;
                    pendAddr = memAddr;
                end
                if (pendCnt > 0) begin
                    pendCnt--;
                    if (pendCnt == 0) begin
                        memResp  = 1'b1;
                        memRdata = memData(pendAddr);
                    end
                end
            end
        end
    end

    // Transaction-level model of the arbiter
    logic          mPendV[2];
    logic          mPendWr[2];
    logic [AW-1:0] mPendAddr[2];
    logic [LW-1:0] mPendWd[2];
    logic          mBusy;
    int            mOwner, mAge, mLast;
    logic          eMemRead, eMemWrite, eError;
    logic [AW-1:0] eMemAddr;
    logic [LW-1:0] eMemWdata;
    logic          eResp[2];
    logic [LW-1:0] eRdata[2];
    logic          modelArmed = 1'b0;

    task automatic modelReset();
        for (int p = 0; p < 2; p++) begin
            mPendV[p] = 1'b0; mPendWr[p] = 1'b0; mPendAddr[p] = '0; mPendWd[p] = '0;
            eResp[p] = 1'b0; eRdata[p] = '0;
        end
        mBusy = 1'b0; mOwner = 0; mAge = 0; mLast = 1;
        eMemRead = 1'b0; eMemWrite = 1'b0; eError = 1'b0; eMemAddr = '0; eMemWdata = '0;
    endtask

    task automatic modelStep();
        int            done;
        int            pick;
        logic          rdIn[2];
        logic          wrIn[2];
        logic [AW-1:0] adIn[2];
        logic [LW-1:0] wdIn[2];
        rdIn[0] = aRead; wrIn[0] = aWrite; adIn[0] = aAddr; wdIn[0] = aWdata;
        rdIn[1] = bRead; wrIn[1] = bWrite; adIn[1] = bAddr; wdIn[1] = bWdata;
        done = -1;
        eMemRead = 1'b0; eMemWrite = 1'b0; eError = 1'b0;
        eResp[0] = 1'b0; eResp[1] = 1'b0;
        if (mBusy) begin
            if (memResp) begin
                eRdata[mOwner] = memRdata;
                done = mOwner;
            end else if (TO != 0 && mAge == TO - 1) begin
                eRdata[mOwner] = '0;
                eError = 1'b1;
                done = mOwner;
            end else begin
                mAge++;
            end
            if (done >= 0) begin
                eResp[done] = 1'b1;
                mBusy = 1'b0;
                mLast = done;
                mPendV[done] = 1'b0;
            end
        end else if (mPendV[0] || mPendV[1]) begin
            if (mPendV[0] && mPendV[1]) pick = 1 - mLast;
            else pick = mPendV[0] ? 0 : 1;
            mBusy = 1'b1; mOwner = pick; mAge = 0;
            if (mPendWr[pick]) eMemWrite = 1'b1; else eMemRead = 1'b1;
            eMemAddr = mPendAddr[pick];
            eMemWdata = mPendWd[pick];
        end
        for (int p = 0; p < 2; p++) begin
            if (rdIn[p] || wrIn[p]) begin
                if (!mPendV[p]) begin
                    mPendV[p] = 1'b1; mPendWr[p] = wrIn[p];
                    mPendAddr[p] = adIn[p]; mPendWd[p] = wdIn[p];
                end else begin
                    eError = 1'b1;
                end
            end
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) modelReset();
            else modelStep();
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && modelArmed) begin
                checkOutput("mem_read", memRead, eMemRead);
                checkOutput("mem_write", memWrite, eMemWrite);
                checkOutput("mem_addr", memAddr, eMemAddr);
                checkOutput("mem_wdata", memWdata, eMemWdata);
                checkOutput("a_resp", aResp, eResp[0]);
                checkOutput("b_resp", bResp, eResp[1]);
                checkOutput("a_rdata", aRdata, eRdata[0]);
                checkOutput("b_rdata", bRdata, eRdata[1]);
                checkOutput("error", errorOut, eError);
            end
        end
    end

    // which: 0 = memory command, 1 = a_resp, 2 = b_resp
    task automatic waitEvent(input int which, input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       seen = memRead | memWrite;
                1:       seen = aResp;
                default: seen = bResp;
            endcase
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_%0d: event not seen within %0d cycles", which, budget);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        aRead = 1'b0; aWrite = 1'b0; bRead = 1'b0; bWrite = 1'b0;
        strayResp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle request pulse on a port, issued at the current negedge
    task automatic applyStimulus(input int port, input logic rd, input logic wr,
                                 input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        if (port == 0) begin aRead = rd; aWrite = wr; aAddr = addr; aWdata = wd; end
        else begin bRead = rd; bWrite = wr; bAddr = addr; bWdata = wd; end
        @(negedge clk);
        aRead = 1'b0; aWrite = 1'b0; bRead = 1'b0; bWrite = 1'b0;
    endtask

    int n;
    int grants;
    int grantOrder[6];
    int errCnt, cmdCnt, respCnt;

    initial begin
        rst = 1'b0;
        aRead = 1'b0; aWrite = 1'b0; bRead = 1'b0; bWrite = 1'b0;
        aAddr = '0; bAddr = '0; aWdata = '0; bWdata = '0;
        #1 rst = 1'b1;
        doReset();
        modelArmed = 1'b1;

        // Reset state
        #1;
        checkOutput("rst_mem_read", memRead, 1'b0);
        checkOutput("rst_a_resp", aResp, 1'b0);
        checkOutput("rst_b_resp", bResp, 1'b0);
        checkOutput("rst_error", errorOut, 1'b0);
        checkOutput("rst_mem_addr", memAddr, '0);

        // Single read on A, memory answers 3 cycles after the command
        @(negedge clk);
        respDelay = 3;
        applyStimulus(0, 1'b1, 1'b0, 32'h40, '0);
        waitEvent(0, 5, n);
        checkOutput("t1_cmd_latency", n, 1);
        checkOutput("t1_mem_read", memRead, 1'b1);
        checkOutput("t1_mem_addr", memAddr, 32'h40);
        @(negedge clk);
        checkOutput("t1_mem_read_1cyc", memRead, 1'b0);
        waitEvent(1, 10, n);
        checkOutput("t1_resp_latency", n, 2);
        checkOutput("t1_a_rdata", aRdata, 128'hDEADBEEF_00000040_FFFFFFBF_0BADF00D);
        checkOutput("t1_b_resp", bResp, 1'b0);
        @(negedge clk);
        checkOutput("t1_a_resp_1cyc", aResp, 1'b0);

        // A read and B write in the same cycle: A first, B on the next edge
        doReset();
        respDelay = 1;
        bWrite = 1'b1; bAddr = 32'h90; bWdata = 128'h11112222_33334444_55556666_77778888;
        applyStimulus(0, 1'b1, 1'b0, 32'h80, '0);
        waitEvent(0, 5, n);
        checkOutput("t2_first_read", memRead, 1'b1);
        checkOutput("t2_first_addr", memAddr, 32'h80);
        waitEvent(1, 5, n);
        checkOutput("t2_a_rdata", aRdata, 128'hDEADBEEF_00000080_FFFFFF7F_0BADF00D);
        @(negedge clk);
        checkOutput("t2_b_write", memWrite, 1'b1);
        checkOutput("t2_b_addr", memAddr, 32'h90);
        checkOutput("t2_b_wdata", memWdata, 128'h11112222_33334444_55556666_77778888);
        waitEvent(2, 5, n);

        // Fairness: each completing port re-requests on its completion edge
        doReset();
        respDelay = 1;
        grants = 0;
        bRead = 1'b1; bAddr = 32'h200;
        applyStimulus(0, 1'b1, 1'b0, 32'h100, '0);
        for (int i = 0; i < 40; i++) begin
            aRead = 1'b0; bRead = 1'b0;
            if ((memRead || memWrite) && grants < 6) begin
                grantOrder[grants] = (memAddr[9:8] == 2'd1) ? 0 : 1;
                grants++;
                if (memAddr[9:8] == 2'd1) begin aRead = 1'b1; aAddr = 32'h100 + grants; end
                else begin bRead = 1'b1; bAddr = 32'h200 + grants; end
            end
            @(negedge clk);
        end
        aRead = 1'b0; bRead = 1'b0;
        checkOutput("t3_grant_count", grants, 6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("t3_grant_%0d", i), grantOrder[i], i % 2);

        // Overrun: B pulses again while its first write is pending
        doReset();
        respDelay = 4;
        errCnt = 0; cmdCnt = 0; respCnt = 0;
        for (int i = 0; i < 16; i++) begin
            bWrite = (i == 0 || i == 2);
            bAddr  = (i == 0) ? 32'h300 : 32'h304;
            bWdata = 128'hABCD;
            @(negedge clk);
            if (errorOut) errCnt++;
            if (memWrite || memRead) cmdCnt++;
            if (bResp) respCnt++;
        end
        bWrite = 1'b0;
        checkOutput("t4_error_pulses", errCnt, 1);
        checkOutput("t4_mem_cmds", cmdCnt, 1);
        checkOutput("t4_b_resps", respCnt, 1);

        // Timeout: first load a_rdata, then let a read go unanswered
        doReset();
        respDelay = 1;
        applyStimulus(0, 1'b1, 1'b0, 32'h44, '0);
        waitEvent(1, 10, n);
        @(negedge clk);
        respDelay = 0;
        applyStimulus(0, 1'b1, 1'b0, 32'h48, '0);
        waitEvent(0, 5, n);
        waitEvent(1, 12, n);
        checkOutput("t5_timeout_cycles", n, 4);
        checkOutput("t5_error", errorOut, 1'b1);
        checkOutput("t5_a_rdata_zero", aRdata, '0);
        @(negedge clk);
        checkOutput("t5_error_1cyc", errorOut, 1'b0);
        strayResp = 1'b1;
        @(negedge clk);
        strayResp = 1'b0;
        respCnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (aResp || bResp) respCnt++;
        end
        checkOutput("t5_stray_ignored", respCnt, 0);

        // Asynchronous reset in the middle of a transaction
        doReset();
        respDelay = 3;
        applyStimulus(0, 1'b1, 1'b0, 32'h50, '0);
        waitEvent(0, 5, n);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_async_mem_addr", memAddr, '0);
        checkOutput("t6_async_mem_read", memRead, 1'b0);
        checkOutput("t6_async_a_rdata", aRdata, '0);
        checkOutput("t6_async_error", errorOut, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        strayResp = 1'b1;
        @(negedge clk);
        strayResp = 1'b0;
        respCnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (aResp || bResp) respCnt++;
        end
        checkOutput("t6_no_resp_after_rst", respCnt, 0);
        respDelay = 2;
        applyStimulus(1, 1'b1, 1'b0, 32'h60, '0);
        waitEvent(2, 10, n);
        checkOutput("t6_b_rdata", bRdata, 128'hDEADBEEF_00000060_FFFFFF9F_0BADF00D);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
